// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI-to-SRAM bridges: response codes, FSM encoding
// and the byte-lane mask helper used by both the write and read sides.
package axi_sram_pkg;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_RESP  = 2'd2
   } bridge_state_t;

   // Lanes covered by a (1 << size)-byte beat starting at byte offset lo.
   // Sizes wider than the 8-byte bus yield no lanes.
   function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] lo);
      logic [15:0] m;
      m = '0;
      if (size <= 3'd3) begin
         m = ((16'd1 << (16'd1 << size)) - 16'd1) << lo;
      end
      return m[7:0];
   endfunction

endpackage

// File: rtl/axi_sram_wr_bridge.sv
// Single-outstanding AXI write responder: captures AW and W in any order,
// issues one byte-enabled SRAM write, then returns a B response with the held ID.
module axi_sram_wr_bridge
   import axi_sram_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int NB     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ID_W-1:0]   awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [2:0]        awsize,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [NB-1:0]     wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [NB-1:0]     ram_wen
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // ready never depends on valid; bid/bresp hold while bvalid && !bready.
   bridge_state_t state, state_nxt;

   logic [ID_W-1:0]   aw_id;
   logic [ADDR_W-1:0] aw_addr;
   logic [2:0]        aw_size;
   logic              aw_got;
   logic [DATA_W-1:0] w_data;
   logic [NB-1:0]     w_strb;
   logic              w_last;
   logic              w_got;

   logic aw_fire, w_fire, both_in, wr_err;
   logic [NB-1:0] wen_mask;

   assign aw_fire = awvalid && (state == ST_IDLE) && !aw_got;
   assign w_fire  = wvalid  && (state == ST_IDLE) && !w_got;
   assign both_in = (aw_got || aw_fire) && (w_got || w_fire);

   // Alignment test only matters for legal sizes; oversize is already an error.
   assign wr_err = (aw_size > 3'd3)
                || ((aw_addr[2:0] & 3'((4'd1 << aw_size) - 4'd1)) != 3'b000)
                || !w_last;

   assign wen_mask = NB'(lane_mask(aw_size, aw_addr[2:0]));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         aw_id   <= '0;
         aw_addr <= '0;
         aw_size <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         w_last  <= 1'b0;
      end else if (state == ST_RESP && bready) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else begin
         if (aw_fire) begin
            aw_got  <= 1'b1;
            aw_id   <= awid;
            aw_addr <= awaddr;
            aw_size <= awsize;
         end
         if (w_fire) begin
            w_got  <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
            w_last <= wlast;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      bid       = '0;
      bresp     = BRESP_OKAY;
      ram_waddr = '0;
      ram_wdata = '0;
      ram_wen   = '0;
      case (state)
         ST_IDLE: begin
            awready = !aw_got;
            wready  = !w_got;
            if (both_in) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (!wr_err) begin
               ram_waddr = {aw_addr[ADDR_W-1:3], 3'b000};
               ram_wdata = w_data;
               ram_wen   = w_strb & wen_mask;
            end
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            bvalid = 1'b1;
            bid    = aw_id;
            bresp  = wr_err ? BRESP_SLVERR : BRESP_OKAY;
            if (bready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
